sem_rr_arbiter: RTL

- Shares one semaphore mailbox channel between NUM_REQ CPU requesters (bit and byte units) using round-robin arbitration.
- Accepted words are stored with the requester ID in an internal FIFO.
- The consumer drains the FIFO through the standard sem_data_* interface (data/valid/read/empty).
- Sits between the CPU sem_data_* output ports and the semaphore consumer.

---
 rtl/sem_rr_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sem_rr_arbiter.sv
// Round-robin arbiter that funnels NUM_REQ semaphore requesters into one tagged FIFO.
// Optional macro SEM_ARB_STATS_EN adds a sticky error flag and per-requester grant counters.
module sem_rr_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ack_out,
  output logic [DATA_WIDTH-1:0]         sem_data_out,
  output logic [ID_W-1:0]               sem_src_out,
  output logic                          sem_data_valid_out,
  input  logic                          sem_data_read,
  output logic                          sem_data_empty,
  output logic                          sem_full,
  output logic [$clog2(FIFO_DEPTH):0]   sem_count
`ifdef SEM_ARB_STATS_EN
  ,
  output logic                          sem_err_out,
  output logic [NUM_REQ*16-1:0]         sem_grant_cnt_out
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Returns {found, id} of the first eligible requester after 'last', wrapping.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] elig,
                                            input logic [ID_W-1:0]    last);
    logic [ID_W:0] res;
    int            idx;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last) + k) % NUM_REQ;
      if (!res[ID_W] && elig[idx]) begin
        res = {1'b1, ID_W'(idx)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_d [FIFO_DEPTH];
  logic [ID_W-1:0]       mem_src_q  [FIFO_DEPTH];
  logic [ID_W-1:0]       mem_src_d  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d, empty_q, empty_d;
  logic [ID_W-1:0]       last_grant_q, last_grant_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;
  logic [ID_W-1:0]       head_src_q, head_src_d;

  logic [ID_W:0]         pick_s;
  logic                  push_s, pop_s;
  logic [ID_W-1:0]       win_id_s;
  logic [DATA_WIDTH-1:0] win_data_s;

  // Arbitration, FIFO pointer/occupancy update and registered head view.
  always_comb begin
    // Acked requesters are masked so a word is never taken twice while valid drops.
    pick_s       = rr_pick(req_valid_in & ~ack_q, last_grant_q);
    push_s       = pick_s[ID_W] & ~full_q;
    pop_s        = sem_data_read & ~empty_q;
    win_id_s     = pick_s[ID_W-1:0];
    win_data_s   = req_data_in[int'(win_id_s)*DATA_WIDTH +: DATA_WIDTH];
    mem_data_d   = mem_data_q;
    mem_src_d    = mem_src_q;
    ack_d        = '0;
    head_data_d  = head_data_q;
    head_src_d   = head_src_q;
    if (push_s) begin
      mem_data_d[wr_ptr_q] = win_data_s;
      mem_src_d[wr_ptr_q]  = win_id_s;
      ack_d[win_id_s]      = 1'b1;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      last_grant_d         = win_id_s;
    end else begin
      wr_ptr_d             = wr_ptr_q;
      last_grant_d         = last_grant_q;
    end
    rd_ptr_d = pop_s ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == CNT_W'(0));
    // The incoming word becomes head when nothing older survives this edge.
    if (push_s && (empty_q || (pop_s && count_q == CNT_W'(1)))) begin
      head_data_d = win_data_s;
      head_src_d  = win_id_s;
    end else if (pop_s) begin
      head_data_d = mem_data_q[rd_ptr_q + PTR_W'(1)];
      head_src_d  = mem_src_q[rd_ptr_q + PTR_W'(1)];
    end else begin
      head_data_d = head_data_q;
      head_src_d  = head_src_q;
    end
  end

  // State registers; reset discards all queued words and restores requester 0 priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_src_q[i]  <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      ack_q        <= '0;
      head_data_q  <= '0;
      head_src_q   <= '0;
    end else begin
      mem_data_q   <= mem_data_d;
      mem_src_q    <= mem_src_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      last_grant_q <= last_grant_d;
      ack_q        <= ack_d;
      head_data_q  <= head_data_d;
      head_src_q   <= head_src_d;
    end
  end

  assign req_ack_out        = ack_q;
  assign sem_data_out       = head_data_q;
  assign sem_src_out        = head_src_q;
  assign sem_data_valid_out = ~empty_q;
  assign sem_data_empty     = empty_q;
  assign sem_full           = full_q;
  assign sem_count          = count_q;

`ifdef SEM_ARB_STATS_EN
  logic [15:0] wait_q [NUM_REQ];
  logic [15:0] wait_d [NUM_REQ];
  logic [15:0] gcnt_q [NUM_REQ];
  logic [15:0] gcnt_d [NUM_REQ];
  logic        err_q, err_d;

  // Starvation watchdogs, underflow detection and saturating grant counters.
  always_comb begin
    wait_d = wait_q;
    gcnt_d = gcnt_q;
    err_d  = err_q | (sem_data_read & empty_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ack_q[i] || !req_valid_in[i]) begin
        wait_d[i] = 16'h0000;
      end else if (wait_q[i] != 16'hFFFF) begin
        wait_d[i] = wait_q[i] + 16'h0001;
      end else begin
        err_d = 1'b1;
      end
      if (push_s && win_id_s == ID_W'(i) && gcnt_q[i] != 16'hFFFF) begin
        gcnt_d[i] = gcnt_q[i] + 16'h0001;
      end else begin
        gcnt_d[i] = gcnt_q[i];
      end
    end
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        wait_q[i] <= 16'h0000;
        gcnt_q[i] <= 16'h0000;
      end
      err_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      gcnt_q <= gcnt_d;
      err_q  <= err_d;
    end
  end

  // Flatten the per-requester grant counters onto the output bus.
  always_comb begin
    sem_grant_cnt_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sem_grant_cnt_out[i*16 +: 16] = gcnt_q[i];
    end
  end

  assign sem_err_out = err_q;
`endif

endmodule
